// File: rtl/c7bbiu_axi_rd_port_pkg.sv
// Shared AXI read-port constants: requester RIDs, response and burst codes.
package c7bbiu_axi_rd_port_pkg;

  localparam logic [7:0] AXI_RID_IFU = 8'h1;
  localparam logic [7:0] AXI_RID_LSU = 8'h2;
  localparam logic [7:0] AXI_RID_ICU = 8'h4;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  // Source index -> owned RID; sources beyond the named three get 8+s.
  function automatic logic [7:0] src_id(input int s);
    case (s)
      0:       return AXI_RID_IFU;
      1:       return AXI_RID_LSU;
      2:       return AXI_RID_ICU;
      default: return 8'(8 + s);
    endcase
  endfunction

endpackage

// File: rtl/c7bbiu_axi_rd_port_if.sv
// Bus bundle for the read port: arbiter request, AXI AR/R channels and consumer side.
interface c7bbiu_axi_rd_port_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int NUM_SRC = 3
);
  logic              arb_rd_val;
  logic [ID_W-1:0]   arb_rd_id;
  logic [ADDR_W-1:0] arb_rd_addr;
  logic [7:0]        arb_rd_len;
  logic [2:0]        arb_rd_size;
  logic [1:0]        arb_rd_burst;
  logic              arb_rd_lock;
  logic [3:0]        arb_rd_cache;
  logic [2:0]        arb_rd_prot;
  logic              axi_ar_ready;

  logic              ext_biu_ar_ready;
  logic              biu_ext_ar_valid;
  logic [ID_W-1:0]   biu_ext_ar_id;
  logic [ADDR_W-1:0] biu_ext_ar_addr;
  logic [7:0]        biu_ext_ar_len;
  logic [2:0]        biu_ext_ar_size;
  logic [1:0]        biu_ext_ar_burst;
  logic              biu_ext_ar_lock;
  logic [3:0]        biu_ext_ar_cache;
  logic [2:0]        biu_ext_ar_prot;

  logic              ext_biu_r_valid;
  logic [ID_W-1:0]   ext_biu_r_id;
  logic [DATA_W-1:0] ext_biu_r_data;
  logic              ext_biu_r_last;
  logic [1:0]        ext_biu_r_resp;
  logic              biu_ext_r_ready;

  logic               axi_rd_ready;
  logic [DATA_W-1:0]  axi_rdata;
  logic [NUM_SRC-1:0] axi_rdata_val;
  logic               axi_rdata_last;
  logic               axi_rdata_err;
  logic               axi_rd_idle;
  logic               axi_rd_proto_err;

  modport slave (
    input  arb_rd_val, arb_rd_id, arb_rd_addr, arb_rd_len, arb_rd_size, arb_rd_burst,
           arb_rd_lock, arb_rd_cache, arb_rd_prot,
           ext_biu_ar_ready,
           ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last, ext_biu_r_resp,
           axi_rd_ready,
    output axi_ar_ready,
           biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ext_ar_len, biu_ext_ar_size,
           biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot,
           biu_ext_r_ready,
           axi_rdata, axi_rdata_val, axi_rdata_last, axi_rdata_err, axi_rd_idle, axi_rd_proto_err
  );

  modport master (
    output arb_rd_val, arb_rd_id, arb_rd_addr, arb_rd_len, arb_rd_size, arb_rd_burst,
           arb_rd_lock, arb_rd_cache, arb_rd_prot,
           ext_biu_ar_ready,
           ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last, ext_biu_r_resp,
           axi_rd_ready,
    input  axi_ar_ready,
           biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ext_ar_len, biu_ext_ar_size,
           biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot,
           biu_ext_r_ready,
           axi_rdata, axi_rdata_val, axi_rdata_last, axi_rdata_err, axi_rd_idle, axi_rd_proto_err
  );

endinterface

// File: rtl/c7bbiu_axi_rd_port_sync_fifo.sv
// Small FIFO with async active-low reset; head is visible combinationally for skid use.
module c7bbiu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= f_next(r_wptr);
      if (w_pop_ok)  r_rptr <= f_next(r_rptr);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/c7bbiu_axi_rd_port.sv
// AXI read port: AR skid buffer with outstanding limit, in-order burst tracker,
// RID fan-out of R beats to requesters and sticky protocol checking.
module c7bbiu_axi_rd_port
  import c7bbiu_axi_rd_port_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int NUM_SRC  = 3,
  parameter int MAX_OUTS = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  c7bbiu_axi_rd_port_if.slave  bus
);
  localparam int AR_W  = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3;
  localparam int TRK_W = ID_W + 8;
  localparam int OUT_W = $clog2(MAX_OUTS + 1);

  logic [AR_W-1:0]  w_skid_head;
  logic             w_skid_full;
  logic             w_skid_empty;
  logic [1:0]       w_skid_cnt;
  logic             w_skid_push;
  logic             w_ar_hs;
  logic             w_ar_ready;
  logic [OUT_W:0]   w_pending;

  logic [TRK_W-1:0] w_trk_head;
  logic             w_trk_full;
  logic             w_trk_empty;
  logic [OUT_W-1:0] w_outs;
  logic [ID_W-1:0]  w_trk_id;
  logic [7:0]       w_trk_len;
  logic             w_trk_pop;

  logic             w_beat;
  logic             w_proto_viol;
  logic [7:0]       r_beat_cnt;
  logic             r_proto_err;

  // ---------------- AR skid ----------------
  // Ready depends only on registered occupancy, so ARREADY never reaches the arbiter.
  assign w_pending   = {1'b0, w_outs} + (OUT_W + 1)'(w_skid_cnt);
  assign w_ar_ready  = ~w_skid_full & ~w_trk_full & (w_pending < (OUT_W + 1)'(MAX_OUTS));
  assign w_skid_push = bus.arb_rd_val & w_ar_ready;
  assign w_ar_hs     = ~w_skid_empty & bus.ext_biu_ar_ready;

  c7bbiu_sync_fifo #(.WIDTH(AR_W), .DEPTH(2)) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_skid_push),
    .i_data  ({bus.arb_rd_id, bus.arb_rd_addr, bus.arb_rd_len, bus.arb_rd_size,
               bus.arb_rd_burst, bus.arb_rd_lock, bus.arb_rd_cache, bus.arb_rd_prot}),
    .i_pop   (w_ar_hs),
    .o_data  (w_skid_head),
    .o_full  (w_skid_full),
    .o_empty (w_skid_empty),
    .o_count (w_skid_cnt)
  );

  assign bus.axi_ar_ready     = w_ar_ready;
  assign bus.biu_ext_ar_valid = ~w_skid_empty;
  assign {bus.biu_ext_ar_id, bus.biu_ext_ar_addr, bus.biu_ext_ar_len, bus.biu_ext_ar_size,
          bus.biu_ext_ar_burst, bus.biu_ext_ar_lock, bus.biu_ext_ar_cache,
          bus.biu_ext_ar_prot} = w_skid_head;

  // ---------------- burst tracker ----------------
  // Tracker occupancy is the outstanding-read count: both move on AR handshake and RLAST.
  c7bbiu_sync_fifo #(.WIDTH(TRK_W), .DEPTH(MAX_OUTS)) u_trk (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_ar_hs),
    .i_data  ({bus.biu_ext_ar_id, bus.biu_ext_ar_len}),
    .i_pop   (w_trk_pop),
    .o_data  (w_trk_head),
    .o_full  (w_trk_full),
    .o_empty (w_trk_empty),
    .o_count (w_outs)
  );

  assign w_trk_id  = w_trk_head[TRK_W-1 -: ID_W];
  assign w_trk_len = w_trk_head[7:0];

  // ---------------- R channel ----------------
  assign bus.biu_ext_r_ready = bus.axi_rd_ready;
  assign w_beat    = bus.ext_biu_r_valid & bus.axi_rd_ready;
  assign w_trk_pop = w_beat & bus.ext_biu_r_last & ~w_trk_empty;

  assign w_proto_viol = w_beat & ( w_trk_empty
                                 | (bus.ext_biu_r_id != w_trk_id)
                                 | ( bus.ext_biu_r_last & (r_beat_cnt != w_trk_len))
                                 | (~bus.ext_biu_r_last & (r_beat_cnt == w_trk_len)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_beat) r_beat_cnt <= bus.ext_biu_r_last ? 8'd0 : r_beat_cnt + 8'd1;
      r_proto_err <= r_proto_err | w_proto_viol;
    end
  end

  assign bus.axi_rdata      = bus.ext_biu_r_data;
  assign bus.axi_rdata_last = w_beat & bus.ext_biu_r_last;
  assign bus.axi_rdata_err  = w_beat & (bus.ext_biu_r_resp != AXI_RESP_OKAY);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign bus.axi_rdata_val[gi] = w_beat & (bus.ext_biu_r_id == ID_W'(src_id(gi)));
  end

  assign bus.axi_rd_idle      = w_skid_empty & w_trk_empty;
  assign bus.axi_rd_proto_err = r_proto_err;

endmodule

// File: tb/tb_c7bbiu_axi_rd_port.sv
// Directed bench for c7bbiu_axi_rd_port: R-beat vector table plus AR handshake sequences.
module tb_c7bbiu_axi_rd_port;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, NUM_SRC = 3, MAX_OUTS = 4;
  localparam logic [3:0] ID_IFU = 4'h1, ID_LSU = 4'h2, ID_ICU = 4'h4;

  typedef struct {
    logic       v;
    logic [3:0] id;
    logic       last;
    logic [1:0] resp;
    logic       rdy;
    logic [2:0] e_val;
    logic       e_last;
    logic       e_err;
    logic       e_proto;
  } rvec_t;

  logic  clk;
  logic  resetn;
  int    n_checks;
  int    n_errors;
  int    hs;
  int    acc;
  int    m;
  int    k;
  bit    got;
  rvec_t vt [18];
  logic [31:0] t3_addr [3];

  c7bbiu_axi_rd_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_SRC(NUM_SRC)) bus ();

  c7bbiu_axi_rd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_SRC(NUM_SRC),
                       .MAX_OUTS(MAX_OUTS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.arb_rd_val = 1'b0;  bus.arb_rd_id = '0;   bus.arb_rd_addr = '0;  bus.arb_rd_len = '0;
    bus.arb_rd_size = 3'd3; bus.arb_rd_burst = 2'b01; bus.arb_rd_lock = 1'b0;
    bus.arb_rd_cache = 4'h3; bus.arb_rd_prot = 3'h2;
    bus.ext_biu_ar_ready = 1'b0;
    bus.ext_biu_r_valid = 1'b0; bus.ext_biu_r_id = '0; bus.ext_biu_r_data = '0;
    bus.ext_biu_r_last = 1'b0;  bus.ext_biu_r_resp = 2'b00;
    bus.axi_rd_ready = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bus.arb_rd_id = id; bus.arb_rd_addr = addr; bus.arb_rd_len = len;
  endtask

  // Offer one request and wait (bounded) until the port takes it.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    drive_req(id, addr, len);
    bus.arb_rd_val = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.axi_ar_ready;
      @(posedge clk); #1;
    end
    bus.arb_rd_val = 1'b0;
    chk("ar_accept", 64'(ok), 64'd1);
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bus.ext_biu_ar_ready = 1'b1;
    send_ar(id, addr, len);
    @(negedge clk);
    chk("issue_ar_valid", 64'(bus.biu_ext_ar_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vecs(input int first, input int last_i);
    for (int i = first; i <= last_i; i++) begin
      bus.ext_biu_r_valid = vt[i].v;    bus.ext_biu_r_id   = vt[i].id;
      bus.ext_biu_r_last  = vt[i].last; bus.ext_biu_r_resp = vt[i].resp;
      bus.axi_rd_ready    = vt[i].rdy;
      bus.ext_biu_r_data  = 64'hC0DE_0000_0000_0000 | 64'(i);
      @(negedge clk);
      chk($sformatf("v%0d_val", i),   64'(bus.axi_rdata_val),    64'(vt[i].e_val));
      chk($sformatf("v%0d_last", i),  64'(bus.axi_rdata_last),   64'(vt[i].e_last));
      chk($sformatf("v%0d_err", i),   64'(bus.axi_rdata_err),    64'(vt[i].e_err));
      chk($sformatf("v%0d_proto", i), 64'(bus.axi_rd_proto_err), 64'(vt[i].e_proto));
      chk($sformatf("v%0d_rready", i), 64'(bus.biu_ext_r_ready), 64'(vt[i].rdy));
      chk($sformatf("v%0d_data", i),  64'(bus.axi_rdata), 64'hC0DE_0000_0000_0000 | 64'(i));
      @(posedge clk); #1;
    end
    bus.ext_biu_r_valid = 1'b0; bus.ext_biu_r_last = 1'b0; bus.axi_rd_ready = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    //              v     id      last  resp   rdy   val     last  err   proto
    vt[0]  = '{1'b1, ID_ICU, 1'b0, 2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, ID_ICU, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, ID_ICU, 1'b0, 2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, ID_ICU, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, ID_ICU, 1'b0, 2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, ID_ICU, 1'b1, 2'b00, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, ID_LSU, 1'b0, 2'b10, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, ID_LSU, 1'b1, 2'b00, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, ID_IFU, 1'b1, 2'b00, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, ID_IFU, 1'b0, 2'b00, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b1, ID_IFU, 1'b1, 2'b00, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1};
    vt[11] = '{1'b1, ID_LSU, 1'b1, 2'b11, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0};
    vt[12] = '{1'b1, ID_IFU, 1'b1, 2'b00, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b1, ID_ICU, 1'b0, 2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, ID_ICU, 1'b1, 2'b00, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1};
    vt[15] = '{1'b1, ID_IFU, 1'b0, 2'b00, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b1, ID_IFU, 1'b0, 2'b01, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0};
    vt[17] = '{1'b1, ID_ICU, 1'b1, 2'b00, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
    t3_addr[0] = 32'hA000; t3_addr[1] = 32'hB000; t3_addr[2] = 32'hC000;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ar_valid", 64'(bus.biu_ext_ar_valid), 64'd0);
    chk("rst_ar_addr",  64'(bus.biu_ext_ar_addr),  64'd0);
    chk("rst_ar_len",   64'(bus.biu_ext_ar_len),   64'd0);
    chk("rst_idle",     64'(bus.axi_rd_idle),      64'd1);
    chk("rst_proto",    64'(bus.axi_rd_proto_err), 64'd0);
    chk("rst_ar_ready", 64'(bus.axi_ar_ready),     64'd1);
    @(posedge clk); #1;

    // 1: ICU len=3, ARREADY low for 3 cycles, then 4 beats with a stall and a bubble
    drive_req(ID_ICU, 32'h1000, 8'd3);
    bus.arb_rd_val = 1'b1;
    @(negedge clk);
    chk("t1_ready", 64'(bus.axi_ar_ready), 64'd1);
    chk("t1_ar_valid_same_cycle", 64'(bus.biu_ext_ar_valid), 64'd0);
    @(posedge clk); #1;
    bus.arb_rd_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t1_hold%0d_valid", c), 64'(bus.biu_ext_ar_valid), 64'd1);
      chk($sformatf("t1_hold%0d_addr", c),  64'(bus.biu_ext_ar_addr),  64'h1000);
      chk($sformatf("t1_hold%0d_len", c),   64'(bus.biu_ext_ar_len),   64'd3);
      chk($sformatf("t1_hold%0d_id", c),    64'(bus.biu_ext_ar_id),    64'(ID_ICU));
      chk($sformatf("t1_hold%0d_burst", c), 64'(bus.biu_ext_ar_burst), 64'd1);
      @(posedge clk); #1;
    end
    bus.ext_biu_ar_ready = 1'b1;
    @(negedge clk);
    chk("t1_hs_valid", 64'(bus.biu_ext_ar_valid), 64'd1);
    @(posedge clk); #1;
    bus.ext_biu_ar_ready = 1'b0;
    @(negedge clk);
    chk("t1_after_hs_valid", 64'(bus.biu_ext_ar_valid), 64'd0);
    chk("t1_busy_idle",      64'(bus.axi_rd_idle),      64'd0);
    @(posedge clk); #1;
    run_vecs(0, 5);
    @(negedge clk);
    chk("t1_end_idle",  64'(bus.axi_rd_idle),      64'd1);
    chk("t1_end_proto", 64'(bus.axi_rd_proto_err), 64'd0);
    @(posedge clk); #1;

    // 2: back-to-back requests hit the outstanding limit of 4
    do_reset();
    bus.ext_biu_ar_ready = 1'b1;
    drive_req(ID_IFU, 32'h100, 8'd0);
    bus.arb_rd_val = 1'b1;
    hs = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t2_ready_c%0d", c), 64'(bus.axi_ar_ready), (c < 4) ? 64'd1 : 64'd0);
      if (bus.biu_ext_ar_valid && bus.ext_biu_ar_ready) hs++;
      if (bus.axi_ar_ready) acc++;
      @(posedge clk); #1;
    end
    chk("t2_ar_hs",   64'(hs),  64'd4);
    chk("t2_accepts", 64'(acc), 64'd4);
    bus.ext_biu_r_valid = 1'b1; bus.ext_biu_r_id = ID_IFU; bus.ext_biu_r_last = 1'b1;
    @(negedge clk);
    chk("t2_full_ready", 64'(bus.axi_ar_ready),  64'd0);
    chk("t2_full_val",   64'(bus.axi_rdata_val), 64'b001);
    @(posedge clk); #1;
    bus.ext_biu_r_valid = 1'b0; bus.ext_biu_r_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t2_refill_c%0d", c), 64'(bus.axi_ar_ready), (c == 0) ? 64'd1 : 64'd0);
      if (bus.biu_ext_ar_valid && bus.ext_biu_ar_ready) hs++;
      if (bus.axi_ar_ready) acc++;
      @(posedge clk); #1;
    end
    chk("t2_ar_hs_total",   64'(hs),  64'd5);
    chk("t2_accepts_total", 64'(acc), 64'd5);
    bus.arb_rd_val = 1'b0;

    // 3: skid fills with ARREADY low; ARs drain in request order
    do_reset();
    drive_req(ID_LSU, t3_addr[0], 8'd0);
    bus.arb_rd_val = 1'b1;
    k = 0; m = 0;
    for (int c = 0; c < 20 && m < 3; c++) begin
      bus.ext_biu_ar_ready = (c >= 3);
      @(negedge clk);
      got = bus.axi_ar_ready & bus.arb_rd_val;
      if (c == 2) chk("t3_skid_full_ready", 64'(bus.axi_ar_ready), 64'd0);
      if (bus.biu_ext_ar_valid && bus.ext_biu_ar_ready) begin
        chk($sformatf("t3_order%0d", m), 64'(bus.biu_ext_ar_addr), 64'(t3_addr[m]));
        m++;
      end
      @(posedge clk); #1;
      if (got) begin
        k++;
        if (k < 3) bus.arb_rd_addr = t3_addr[k];
        else       bus.arb_rd_val  = 1'b0;
      end
    end
    chk("t3_ar_count", 64'(m), 64'd3);
    bus.arb_rd_val = 1'b0;

    // 4: LSU len=1, error beat then OKAY beat
    do_reset();
    issue(ID_LSU, 32'h2000, 8'd1);
    run_vecs(6, 7);
    @(negedge clk);
    chk("t4_proto", 64'(bus.axi_rd_proto_err), 64'd0);
    chk("t4_idle",  64'(bus.axi_rd_idle),      64'd1);
    @(posedge clk); #1;

    // 5a: early RLAST sets proto; 5b: next burst still tracked
    issue(ID_IFU, 32'h40, 8'd1);
    run_vecs(8, 8);
    @(negedge clk);
    chk("t5a_proto", 64'(bus.axi_rd_proto_err), 64'd1);
    @(posedge clk); #1;
    issue(ID_IFU, 32'h80, 8'd1);
    run_vecs(9, 10);
    @(negedge clk);
    chk("t5b_idle",  64'(bus.axi_rd_idle),      64'd1);
    chk("t5b_proto", 64'(bus.axi_rd_proto_err), 64'd1);
    @(posedge clk); #1;
    // 5c: beat with nothing outstanding
    do_reset();
    run_vecs(11, 11);
    @(negedge clk);
    chk("t5c_proto", 64'(bus.axi_rd_proto_err), 64'd1);
    @(posedge clk); #1;
    // 5d: RID differs from the tracked burst
    do_reset();
    issue(ID_LSU, 32'h200, 8'd0);
    run_vecs(12, 12);
    @(negedge clk);
    chk("t5d_proto", 64'(bus.axi_rd_proto_err), 64'd1);
    chk("t5d_idle",  64'(bus.axi_rd_idle),      64'd1);
    @(posedge clk); #1;
    // 5e: final beat arrives without RLAST
    do_reset();
    issue(ID_ICU, 32'h300, 8'd0);
    run_vecs(13, 14);
    @(negedge clk);
    chk("t5e_proto", 64'(bus.axi_rd_proto_err), 64'd1);
    chk("t5e_idle",  64'(bus.axi_rd_idle),      64'd1);
    @(posedge clk); #1;

    // 6: reset in the middle of a len=7 burst with an AR parked in the skid
    do_reset();
    issue(ID_IFU, 32'h4000, 8'd7);
    bus.ext_biu_ar_ready = 1'b0;
    send_ar(ID_LSU, 32'h5000, 8'd0);
    @(negedge clk);
    chk("t6_pre_ar_valid", 64'(bus.biu_ext_ar_valid), 64'd1);
    chk("t6_pre_idle",     64'(bus.axi_rd_idle),      64'd0);
    @(posedge clk); #1;
    run_vecs(15, 16);
    bus.ext_biu_r_valid = 1'b1; bus.ext_biu_r_id = ID_IFU;
    #2;
    resetn = 1'b0;
    bus.ext_biu_r_valid = 1'b0;
    #1;
    chk("t6_rst_ar_valid", 64'(bus.biu_ext_ar_valid), 64'd0);
    chk("t6_rst_ar_addr",  64'(bus.biu_ext_ar_addr),  64'd0);
    chk("t6_rst_idle",     64'(bus.axi_rd_idle),      64'd1);
    chk("t6_rst_val",      64'(bus.axi_rdata_val),    64'd0);
    do_reset();
    issue(ID_ICU, 32'h6000, 8'd0);
    run_vecs(17, 17);
    @(negedge clk);
    chk("t6_fresh_idle",  64'(bus.axi_rd_idle),      64'd1);
    chk("t6_fresh_proto", 64'(bus.axi_rd_proto_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
